// File: rtl/shift_stage_pkg.sv
// Shared types and helpers for the shift stage controller slice.
package shift_stage_pkg;

    // Controller sequencing: normal flow, emptying on request, one-cycle completion.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ctrl_state_e;

    // Number of bits needed to hold an occupancy value from 0 up to depth.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_stage_controller_stage.sv
// One register of the delay line: a valid flag plus its data word.
// Data only changes when a valid word is loaded, so bubbles and flushes
// leave the last real word in place.
module shift_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    // Clear wins over load so a flush discards whatever was about to arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= src_vld;
            if (src_vld) begin
                dat <= src_dat;
            end
        end
    end

endmodule

// File: rtl/shift_stage_controller.sv
// Fixed-latency delay line with per-stage valid tracking, valid/ready flow
// control, bubble collapsing, synchronous flush and a drain-to-empty handshake.
module shift_stage_controller
    import shift_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    input  logic                       drain_req,
    output logic                       drain_done,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = count_width(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] cap;
    logic [DEPTH-1:0] src_vld;
    logic [DEPTH-1:0] vld_next;
    logic [WIDTH-1:0] dat     [DEPTH];
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    ctrl_state_e state;
    ctrl_state_e state_next;

    // Advance chain from the output back to the input: a stage may move its
    // content forward when the stage after it is empty or itself moving.
    // cap[i] says stage i can take new content this cycle.
    always_comb begin
        adv = '0;
        cap = '0;
        adv[DEPTH-1] = out_ready || !vld[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] || !vld[i+1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            cap[i] = !vld[i] || adv[i];
        end
    end

    assign in_ready = (state == RUN) && cap[0] && !flush;
    assign accept   = in_valid && in_ready;

    // Each stage's source is the previous stage; stage 0 is fed by the producer.
    always_comb begin
        src_vld    = '0;
        src_vld[0] = accept;
        src_dat[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i] = vld[i-1];
            src_dat[i] = dat[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .load    (cap[g]),
                .clear   (flush),
                .src_vld (src_vld[g]),
                .src_dat (src_dat[g]),
                .vld     (vld[g]),
                .dat     (dat[g])
            );
        end
    endgenerate

    // Predicted valid vector after this edge; drives occupancy and drain completion.
    always_comb begin
        vld_next = '0;
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                vld_next[i] = 1'b0;
            end else if (cap[i]) begin
                vld_next[i] = src_vld[i];
            end else begin
                vld_next[i] = vld[i];
            end
            cnt_next = cnt_next + CNT_W'(vld_next[i]);
        end
    end

    // Occupancy register tracks the valid vector it will match next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= cnt_next;
        end
    end

    // Sequencing: a drain request stops intake until the line is empty,
    // then DONE lasts exactly one cycle before returning to normal flow.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (drain_req) state_next = DRAIN;
            DRAIN:   if (vld_next == '0) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    assign drain_done = (state == DONE);
    assign out_valid  = vld[DEPTH-1];
    assign out_data   = dat[DEPTH-1];

endmodule

// File: tb/tb_shift_stage_controller.sv
// Directed bench for shift_stage_controller: a DEPTH=2 and a DEPTH=4 instance
// share the same stimulus; each section checks the instance it targets.
module tb_shift_stage_controller;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic [7:0] inData;
    logic       outReady;
    logic       flush;
    logic       drainReq;

    logic       inReady2,  outValid2,  drainDone2;
    logic [7:0] outData2;
    logic [1:0] count2;
    logic       inReady4,  outValid4,  drainDone4;
    logic [7:0] outData4;
    logic [2:0] count4;

    int errors = 0;
    int checks = 0;

    shift_stage_controller #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady2),
        .in_data    (inData),
        .out_valid  (outValid2),
        .out_ready  (outReady),
        .out_data   (outData2),
        .flush      (flush),
        .drain_req  (drainReq),
        .drain_done (drainDone2),
        .count      (count2)
    );

    shift_stage_controller #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady4),
        .in_data    (inData),
        .out_valid  (outValid4),
        .out_ready  (outReady),
        .out_data   (outData4),
        .flush      (flush),
        .drain_req  (drainReq),
        .drain_done (drainDone4),
        .count      (count4)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive all non-reset inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic iv, input logic [7:0] d,
                                 input logic ordy, input logic fl, input logic dr);
        inValid  = iv;
        inData   = d;
        outReady = ordy;
        flush    = fl;
        drainReq = dr;
        #1;
    endtask

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full directed sequence.
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("[TB] reset state");
        checkOutput("rst_out_valid",  outValid2,  1'b0);
        checkOutput("rst_out_data",   outData2,   8'h00);
        checkOutput("rst_count",      count2,     2'd0);
        checkOutput("rst_drain_done", drainDone2, 1'b0);
        checkOutput("rst_in_ready",   inReady2,   1'b1);
        checkOutput("rst_count4",     count4,     3'd0);

        $display("[TB] streaming 01..05");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
            checkOutput("stream_in_ready", inReady2, 1'b1);
            tick();
            if (k == 1) begin
                checkOutput("stream_first_out_valid", outValid2, 1'b0);
                checkOutput("stream_first_count",     count2,    2'd1);
            end else begin
                checkOutput("stream_out_valid", outValid2, 1'b1);
                checkOutput("stream_out_data",  outData2,  32'(k - 1));
                checkOutput("stream_count",     count2,    2'd2);
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("stream_tail_data",  outData2, 8'h05);
        checkOutput("stream_tail_count", count2,   2'd1);
        tick();
        checkOutput("stream_empty_valid", outValid2, 1'b0);
        checkOutput("stream_empty_count", count2,    2'd0);

        $display("[TB] stall with full pipeline");
        applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stall_count",     count2,    2'd2);
        checkOutput("stall_out_valid", outValid2, 1'b1);
        checkOutput("stall_out_data",  outData2,  8'hA0);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_in_ready", inReady2, 1'b0);
        tick();
        checkOutput("stall_hold_count", count2,   2'd2);
        checkOutput("stall_hold_data",  outData2, 8'hA0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("release_data",  outData2, 8'hA1);
        checkOutput("release_count", count2,   2'd1);
        tick();
        checkOutput("release_empty", outValid2, 1'b0);

        rst = 1'b1;
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_count4",     count4,    3'd0);
        checkOutput("rst2_out_valid4", outValid4, 1'b0);

        $display("[TB] bubble collapse on DEPTH=4");
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("bubble_count1", count4, 3'd1);
        tick();
        tick();
        checkOutput("bubble_not_yet", outValid4, 1'b0);
        tick();
        checkOutput("bubble_arrived_valid", outValid4, 1'b1);
        checkOutput("bubble_arrived_data",  outData4,  8'h55);
        for (int w = 0; w < 3; w++) begin
            applyStimulus(1'b1, 8'(8'h56 + w), 1'b0, 1'b0, 1'b0);
            checkOutput("bubble_in_ready", inReady4, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 8'h59, 1'b0, 1'b0, 1'b0);
        checkOutput("bubble_full_count",    count4,   3'd4);
        checkOutput("bubble_full_in_ready", inReady4, 1'b0);
        checkOutput("bubble_full_head",     outData4, 8'h55);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            tick();
            checkOutput("bubble_drain_data",  outData4, 32'(8'h56 + w));
            checkOutput("bubble_drain_count", count4,   32'(3 - w));
        end
        tick();
        checkOutput("bubble_drain_empty", outValid4, 1'b0);

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        $display("[TB] flush");
        applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flush_pre_count", count2, 2'd2);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_in_ready", inReady2, 1'b0);
        tick();
        checkOutput("flush_count",     count2,    2'd0);
        checkOutput("flush_out_valid", outValid2, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flush_no_capture", count2,    2'd0);
        checkOutput("flush_still_empty", outValid2, 1'b0);
        checkOutput("flush_dat_kept",   outData2,  8'hB0);

        $display("[TB] drain on empty pipeline");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("edrain_in_ready",   inReady2,   1'b0);
        checkOutput("edrain_done_early", drainDone2, 1'b0);
        tick();
        checkOutput("edrain_done",          drainDone2, 1'b1);
        checkOutput("edrain_done_in_ready", inReady2,   1'b0);
        tick();
        checkOutput("edrain_done_clear", drainDone2, 1'b0);
        checkOutput("edrain_run_ready",  inReady2,   1'b1);

        $display("[TB] drain with words in flight");
        applyStimulus(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0, 1'b1);
        checkOutput("drain_req_cycle_ready", inReady2, 1'b1);
        tick();
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        checkOutput("drain_in_ready", inReady2,   1'b0);
        checkOutput("drain_data0",    outData2,   8'hC1);
        checkOutput("drain_count0",   count2,     2'd2);
        checkOutput("drain_no_done0", drainDone2, 1'b0);
        tick();
        checkOutput("drain_data1",    outData2,   8'hC2);
        checkOutput("drain_count1",   count2,     2'd1);
        checkOutput("drain_no_done1", drainDone2, 1'b0);
        tick();
        checkOutput("drain_empty", outValid2,  1'b0);
        checkOutput("drain_done",  drainDone2, 1'b1);
        checkOutput("drain_count", count2,     2'd0);
        tick();
        checkOutput("drain_done_pulse", drainDone2, 1'b0);
        checkOutput("drain_back_run",   inReady2,   1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 8'hD2, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("mrst_out_valid", outValid2,  1'b0);
        checkOutput("mrst_out_data",  outData2,   8'h00);
        checkOutput("mrst_count",     count2,     2'd0);
        checkOutput("mrst_done",      drainDone2, 1'b0);
        checkOutput("mrst_in_ready",  inReady2,   1'b1);
        tick();
        checkOutput("mrst_no_drain", drainDone2, 1'b0);
        checkOutput("mrst_run",      inReady2,   1'b1);

        $display("[TB] reset during drain");
        applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("drst_in_ready_drain", inReady2, 1'b0);
        checkOutput("drst_count_held",     count2,   2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("drst_out_valid", outValid2,  1'b0);
        checkOutput("drst_out_data",  outData2,   8'h00);
        checkOutput("drst_count",     count2,     2'd0);
        checkOutput("drst_in_ready",  inReady2,   1'b1);
        checkOutput("drst_done",      drainDone2, 1'b0);
        tick();
        checkOutput("drst_no_done_after", drainDone2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
